// File: rtl/ioctl_dn_buffer.sv
// ioctl_dn_buffer: absorbs ioctl download writes in a small FIFO and replays
// them to the system download port at most once per ce_pix enable.
// dn_busy covers the whole session, including the drain, so the system stays
// in reset until the last buffered byte has been written.
module ioctl_dn_buffer #(
    parameter int DEPTH       = 16,
    parameter int WAIT_MARGIN = 4,
    parameter int ADDR_W      = 14
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    output logic [7:0]        dn_index,
    output logic              dn_wr,
    output logic              dn_busy,
    output logic              dn_done,
    output logic              err_overflow,
    output logic              err_range
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + 16;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(WAIT_MARGIN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next, free_next;
    logic [1:0]    state, state_next;
    logic          full, empty, in_range, wr_req, push, pop, start;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign in_range = (ioctl_addr[24:ADDR_W] == '0);
    assign wr_req   = ioctl_wr & ioctl_download;
    // A pop in the same cycle never makes room for a write that sees full.
    assign push     = wr_req & in_range & ~full;
    assign pop      = ~empty & ce_pix;
    assign start    = (state == S_IDLE) & ioctl_download;

    // Occupancy after this cycle's push/pop, used for the wait threshold.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        free_next = DEPTH_C - count_next;
    end

    // FIFO storage; contents are don't-care while count says empty.
    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout, ioctl_index};
    end

    // Pointers, count and the registered loader stall.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            ioctl_wait <= (free_next <= MARGIN_C);
        end
    end

    // Replay side: head entry lands on dn_* with a one-cycle dn_wr pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dn_wr    <= 1'b0;
            dn_addr  <= '0;
            dn_data  <= '0;
            dn_index <= '0;
        end else begin
            dn_wr <= pop;
            if (pop) {dn_addr, dn_data, dn_index} <= mem[rd_ptr];
        end
    end

    // Sticky drop flags; a new session clears them, a drop in that same
    // cycle still sets them.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            if (start) begin
                err_overflow <= 1'b0;
                err_range    <= 1'b0;
            end
            if (wr_req & in_range & full) err_overflow <= 1'b1;
            if (wr_req & ~in_range)       err_range    <= 1'b1;
        end
    end

    // Session sequencing: DRAIN waits for both an empty FIFO and the last pulse.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (ioctl_download) state_next = S_LOAD;
            S_LOAD:  if (!ioctl_download) state_next = S_DRAIN;
            S_DRAIN: begin
                if (ioctl_download)      state_next = S_LOAD;
                else if (empty && !dn_wr) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    assign dn_busy = (state != S_IDLE);
    assign dn_done = (state == S_DONE);
endmodule

// File: tb/tb_ioctl_dn_buffer.sv
// Directed bench for ioctl_dn_buffer with a scoreboard of expected replays.
module tb_ioctl_dn_buffer;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce_pix, ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic        ioctl_wait;
    logic [13:0] dn_addr;
    logic [7:0]  dn_data, dn_index;
    logic        dn_wr, dn_busy, dn_done, err_overflow, err_range;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [29:0] sb [$];

    ioctl_dn_buffer #(.DEPTH(16), .WAIT_MARGIN(4), .ADDR_W(14)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_wait(ioctl_wait), .dn_addr(dn_addr), .dn_data(dn_data),
        .dn_index(dn_index), .dn_wr(dn_wr), .dn_busy(dn_busy), .dn_done(dn_done),
        .err_overflow(err_overflow), .err_range(err_range)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_wr(input logic [24:0] a, input logic [7:0] d,
                         input logic [7:0] ix, input bit accept);
        ioctl_wr    = 1'b1;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_index = ix;
        if (accept) sb.push_back({a[13:0], d, ix});
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int base;
        bit seen;
        base = done_cnt;
        seen = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (done_cnt != base) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    // Scoreboard consumer: every dn_wr pulse must match the oldest accepted write.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (dn_wr) begin
                wr_cnt++;
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    logic [29:0] e;
                    e = sb.pop_front();
                    check("sb_addr",  dn_addr,  e[29:16]);
                    check("sb_data",  dn_data,  e[15:8]);
                    check("sb_index", dn_index, e[7:0]);
                end
            end
            if (dn_done) done_cnt++;
        end
    end

    initial begin
        int base_wr, base_done, exp_cnt, pulses, last;
        reset_n = 1'b0; ce_pix = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        tick(); tick();
        check("rst_wait", ioctl_wait, 0);
        check("rst_wr",   dn_wr, 0);
        check("rst_busy", dn_busy, 0);
        check("rst_done", dn_done, 0);
        check("rst_addr", dn_addr, 0);
        check("rst_errs", {err_overflow, err_range}, 0);
        reset_n = 1'b1;
        tick();

        // 1: single write, download rising together with the strobe
        ce_pix = 1'b1; ioctl_download = 1'b1;
        do_wr(25'h0123, 8'hA5, 8'h02, 1);
        check("t1_busy", dn_busy, 1);
        check("t1_lat0", dn_wr, 0);
        tick();
        check("t1_lat1", dn_wr, 1);
        check("t1_addr", dn_addr, 14'h0123);
        tick();
        check("t1_pulse_end", dn_wr, 0);
        ioctl_download = 1'b0;
        base_done = done_cnt;
        wait_done("t1_done_seen");
        repeat (5) tick();
        check("t1_done_once", done_cnt - base_done, 1);
        check("t1_busy_low", dn_busy, 0);

        // 2: burst into a stalled drain, backpressure and overflow
        ce_pix = 1'b0; ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            do_wr(25'(i), 8'(8'h40 + i), 8'h05, 1);
            check($sformatf("t2_wait_%0d", i + 1), ioctl_wait, ((16 - (i + 1)) <= 4));
        end
        check("t2_no_ovf_yet", err_overflow, 0);
        do_wr(25'd16, 8'hEE, 8'h05, 0);
        check("t2_overflow", err_overflow, 1);
        base_wr = wr_cnt;
        exp_cnt = 16;
        for (int c = 0; c < 40; c++) begin
            ce_pix = (c % 2 == 0);
            if (ce_pix && exp_cnt > 0) exp_cnt--;
            tick();
            check($sformatf("t2_drain_wait_%0d", c), ioctl_wait, ((16 - exp_cnt) <= 4));
        end
        ce_pix = 1'b0;
        check("t2_pulses", wr_cnt - base_wr, 16);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_ovf_sticky", err_overflow, 1);
        ioctl_download = 1'b0;
        wait_done("t2_done_seen");

        // 3: out-of-range write, flag clears on the next session start
        check("t3_ovf_idle", err_overflow, 1);
        ioctl_download = 1'b1;
        tick();
        check("t3_ovf_cleared", err_overflow, 0);
        base_wr = wr_cnt;
        do_wr(25'h004000, 8'h11, 8'h03, 0);
        check("t3_range", err_range, 1);
        ce_pix = 1'b1;
        repeat (4) tick();
        check("t3_no_wr", wr_cnt - base_wr, 0);
        ioctl_download = 1'b0;
        wait_done("t3_done_seen");
        check("t3_range_sticky", err_range, 1);
        ioctl_download = 1'b1;
        tick();
        check("t3_range_cleared", err_range, 0);

        // 4: ce_pix one cycle in four paces the drain
        ce_pix = 1'b0;
        for (int i = 0; i < 8; i++) do_wr(25'(12'h100 + i), 8'(8'h80 + i), 8'h07, 1);
        ioctl_download = 1'b0;
        pulses = 0; last = 0;
        for (int c = 0; c < 60 && pulses < 8; c++) begin
            ce_pix = (c % 4 == 0);
            tick();
            if (dn_wr) begin
                pulses++;
                if (pulses > 1) check($sformatf("t4_space_%0d", pulses), c - last, 4);
                check($sformatf("t4_busy_%0d", pulses), dn_busy, 1);
                last = c;
            end
        end
        ce_pix = 1'b0;
        check("t4_pulses", pulses, 8);
        tick();
        check("t4_busy_after", dn_busy, 1);
        wait_done("t4_done_seen");

        // 5: session re-entry while the drain is still pending
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) do_wr(25'(12'h200 + i), 8'(8'hC0 + i), 8'h09, 1);
        base_done = done_cnt;
        base_wr = wr_cnt;
        ioctl_download = 1'b0;
        tick(); tick();
        ioctl_download = 1'b1;
        tick();
        check("t5_busy", dn_busy, 1);
        ce_pix = 1'b1;
        repeat (10) tick();
        check("t5_delivered", wr_cnt - base_wr, 5);
        check("t5_no_done", done_cnt - base_done, 0);
        ce_pix = 1'b0;
        ioctl_download = 1'b0;
        wait_done("t5_done_seen");

        // 6: asynchronous reset in the middle of a drain
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) do_wr(25'(12'h300 + i), 8'(8'hD0 + i), 8'h0B, 1);
        ioctl_download = 1'b0;
        tick();
        ce_pix = 1'b1;
        tick();
        check("t6_wr_before", dn_wr, 1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_wr_dropped", dn_wr, 0);
        check("t6_busy", dn_busy, 0);
        check("t6_addr", dn_addr, 0);
        check("t6_wait", ioctl_wait, 0);
        sb.delete();
        base_wr = wr_cnt;
        base_done = done_cnt;
        tick(); tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check("t6_no_wr", wr_cnt - base_wr, 0);
        check("t6_no_done", done_cnt - base_done, 0);
        check("t6_idle", dn_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
